md_sched: RTL and testbench

Multiply/divide scheduler for the five-stage MIPS pipeline. It sits beside the E-stage ALU and owns the HI/LO register pair. It sequences multi-cycle mult/multu/div/divu operations with a down-counter and applies mthi/mtlo writes. It raises a D-stage stall request whenever the instruction in D needs the multiply/divide unit while an operation is in flight.

---
 rtl/md_sched.sv | 134 +++++++++++++
 tb/tb_md_sched.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/md_sched.sv
// Multiply/divide scheduler: owns HI/LO, sequences multi-cycle mult/div, applies mthi/mtlo.
// Optional feature: define MDU_CANCEL_EN to add the cancel port (abort an in-flight operation).
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic        mt_hi,
  input  logic        mt_lo,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use_D,
`ifdef MDU_CANCEL_EN
  input  logic        cancel,
`endif
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic [31:0]        pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic               cancel_w;

`ifdef MDU_CANCEL_EN
  assign cancel_w = cancel;
`else
  assign cancel_w = 1'b0;
`endif

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] quot_s, rem_s;
  logic        [31:0] quot_u, rem_u;
  logic        [31:0] res_hi, res_lo;

  assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
  assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};
  // Signed % keeps the dividend's sign, matching MIPS remainder semantics.
  assign quot_s = $signed(rs_val) / $signed(rt_val);
  assign rem_s  = $signed(rs_val) % $signed(rt_val);
  assign quot_u = rs_val / rt_val;
  assign rem_u  = rs_val % rt_val;

  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    case (md_op)
      2'd0: begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
      2'd1: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      2'd2: if (rt_val != 32'd0) begin res_hi = rem_s; res_lo = quot_s; end
      default: if (rt_val != 32'd0) begin res_hi = rem_u; res_lo = quot_u; end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    case (state_q)
      IDLE: begin
        // A start always drops same-cycle mt writes, even when cancel suppresses it.
        if (start) begin
          if (!cancel_w) begin
            pend_hi_d = res_hi;
            pend_lo_d = res_lo;
            cnt_d     = md_op[1] ? DIV_LD : MULT_LD;
            state_d   = BUSY;
          end
        end else begin
          if (mt_hi) hi_d = rs_val;
          if (mt_lo) lo_d = rs_val;
        end
      end
      BUSY: begin
        if (cancel_w) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CNT_ONE) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Pending result is only meaningful in BUSY, so it needs no reset.
  always_ff @(posedge clk) begin
    pend_hi_q <= pend_hi_d;
    pend_lo_q <= pend_lo_d;
  end

  assign busy     = (state_q == BUSY);
  assign stall_md = md_use_D & (busy | start);
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: table of mult/div vectors plus hand-written timing sequences.
module tb_md_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  md_op = 2'd0;
  logic        mt_hi = 1'b0;
  logic        mt_lo = 1'b0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        md_use_D = 1'b0;
`ifdef MDU_CANCEL_EN
  logic        cancel = 1'b0;
`endif
  logic        busy, stall_md;
  logic [31:0] hi, lo;

  int n_chk = 0;
  int n_fail = 0;

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .mt_hi(mt_hi), .mt_lo(mt_lo), .rs_val(rs_val), .rt_val(rt_val),
    .md_use_D(md_use_D),
`ifdef MDU_CANCEL_EN
    .cancel(cancel),
`endif
    .busy(busy), .stall_md(stall_md), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cyc;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Launch one op and count busy cycles; bounded so a stuck busy cannot hang.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int ncyc);
    start = 1'b1; md_op = op; rs_val = a; rt_val = b;
    tick();
    start = 1'b0;
    ncyc = 0;
    while (busy && ncyc < 40) begin
      ncyc++;
      tick();
    end
  endtask

  initial begin
    int n;
    logic [31:0] save_hi, save_lo;

    vecs[0] = '{2'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1] = '{2'd1, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5};
    vecs[2] = '{2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{2'd3, 32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[4] = '{2'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[5] = '{2'd3, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 10};
    vecs[6] = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    vecs[7] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[8] = '{2'd2, 32'h80000000, 32'd0,        32'hFFFFFFFE, 32'h00000001, 10};
    vecs[9] = '{2'd0, 32'h12345678, 32'd0,        32'h00000000, 32'h00000000, 5};

    // Reset, then idle
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_hi", hi, 32'd0);
      chk("reset_lo", lo, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_stall", {31'd0, stall_md}, 32'd0);
    end

    // mthi alone, then mthi+mtlo together
    mt_hi = 1'b1; rs_val = 32'h1234;
    tick();
    mt_hi = 1'b0;
    chk("mthi_hi", hi, 32'h1234);
    chk("mthi_lo", lo, 32'd0);
    mt_hi = 1'b1; mt_lo = 1'b1; rs_val = 32'hABCD;
    tick();
    mt_hi = 1'b0; mt_lo = 1'b0;
    chk("mtboth_hi", hi, 32'hABCD);
    chk("mtboth_lo", lo, 32'hABCD);

    // Table of arithmetic vectors
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, n);
      chk($sformatf("vec%0d_cycles", i), n, vecs[i].cyc);
      chk($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
      chk($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
    end

    // Stall held through launch and busy
    md_use_D = 1'b1;
    start = 1'b1; md_op = 2'd0; rs_val = 32'd2; rt_val = 32'd2;
    #1;
    chk("stall_launch", {31'd0, stall_md}, 32'd1);
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_busy", {31'd0, busy}, 32'd1);
      chk("stall_during", {31'd0, stall_md}, 32'd1);
      tick();
    end
    chk("stall_after_busy", {31'd0, busy}, 32'd0);
    chk("stall_after", {31'd0, stall_md}, 32'd0);
    chk("stall_res_lo", lo, 32'd4);
    md_use_D = 1'b0;

    // No stall when D does not use the unit
    start = 1'b1; md_op = 2'd0;
    #1;
    chk("nostall_launch", {31'd0, stall_md}, 32'd0);
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("nostall_busy", {31'd0, stall_md}, 32'd0);
      tick();
    end

    // Same-cycle start + mt_lo: mult result wins
    start = 1'b1; mt_lo = 1'b1; md_op = 2'd0; rs_val = 32'd5; rt_val = 32'd7;
    tick();
    start = 1'b0; mt_lo = 1'b0;
    chk("arb_lo_during", lo, 32'd4);
    repeat (5) tick();
    chk("arb_hi", hi, 32'd0);
    chk("arb_lo", lo, 32'd35);

    // mt_hi and start during BUSY are ignored
    start = 1'b1; md_op = 2'd0; rs_val = 32'd3; rt_val = 32'd4;
    tick();
    start = 1'b0;
    tick();
    mt_hi = 1'b1; mt_lo = 1'b1; start = 1'b1; md_op = 2'd2; rs_val = 32'hDEAD; rt_val = 32'd1;
    tick();
    mt_hi = 1'b0; mt_lo = 1'b0; start = 1'b0;
    chk("busy_mt_hi", hi, 32'd0);
    chk("busy_mt_lo", lo, 32'd35);
    n = 2;
    while (busy && n < 40) begin
      n++;
      tick();
    end
    chk("busy_ign_cycles", n, 5);
    chk("busy_ign_hi", hi, 32'd0);
    chk("busy_ign_lo", lo, 32'd12);

    // Back-to-back: new start in the first idle cycle after commit
    run_op(2'd0, 32'd2, 32'd3, n);
    chk("b2b_first_cycles", n, 5);
    chk("b2b_first_lo", lo, 32'd6);
    run_op(2'd2, 32'd100, 32'd7, n);
    chk("b2b_second_cycles", n, 10);
    chk("b2b_second_hi", hi, 32'd2);
    chk("b2b_second_lo", lo, 32'd14);

`ifdef MDU_CANCEL_EN
    // Cancel at busy cycle 4: no commit
    save_hi = hi; save_lo = lo;
    start = 1'b1; md_op = 2'd2; rs_val = 32'd50; rt_val = 32'd3;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("cancel_busy4", {31'd0, busy}, 32'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_busy", {31'd0, busy}, 32'd0);
    repeat (8) tick();
    chk("cancel_hi", hi, save_hi);
    chk("cancel_lo", lo, save_lo);
`else
    save_hi = hi; save_lo = lo;
    chk("pre_reset_hi", save_hi, 32'd2);
    chk("pre_reset_lo", save_lo, 32'd14);
`endif

    // Reset mid-BUSY: busy drops immediately, HI/LO cleared
    start = 1'b1; md_op = 2'd2; rs_val = 32'd9; rt_val = 32'd2;
    tick();
    start = 1'b0;
    tick();
    chk("midrst_busy_pre", {31'd0, busy}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    chk("midrst_busy_after", {31'd0, busy}, 32'd0);
    repeat (12) tick();
    chk("midrst_no_commit_lo", lo, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
